// File: rtl/fetch_unit_pkg.sv
// Shared types for the IF stage: ibus request/response, fetch payload and FSM states.
// fetch_data_t carries a misalign flag only when FETCH_MISALIGN_CHECK_EN is defined.
package fetch_unit_pkg;

    typedef logic        u1;
    typedef logic [31:0] u32;
    typedef logic [63:0] u64;

    localparam u64 PC_RESET_DEFAULT    = 64'h8000_0000;
    localparam int INSTR_BYTES_DEFAULT = 4;

    typedef struct packed {
        u1  valid;
        u64 addr;
    } ibus_req_t;

    typedef struct packed {
        u1  addr_ok;
        u1  data_ok;
        u32 data;
    } ibus_resp_t;

    typedef struct packed {
        u1  valid;
        u64 pc;
        u32 raw_instr;
`ifdef FETCH_MISALIGN_CHECK_EN
        u1  misalign;
`endif
    } fetch_data_t;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD,
        DROP
    } fetch_state_t;

    // Source of the next PC value chosen by the fetch FSM.
    typedef enum logic [1:0] {
        PC_HOLD,
        PC_INC,
        PC_JUMP,
        PC_PEND
    } pc_sel_t;

endpackage

// File: rtl/fetch_unit_pc_sel.sv
// Combinational next-PC mux: hold, sequential increment, redirect target or pending redirect.
module fetch_unit_pc_sel
    import fetch_unit_pkg::*;
#(
    parameter int INSTR_BYTES = INSTR_BYTES_DEFAULT
) (
    input  pc_sel_t     sel_i,
    input  logic [63:0] pc_i,
    input  logic [63:0] jump_pc_i,
    input  logic [63:0] pend_pc_i,
    output logic [63:0] pc_next_o
);

    always_comb begin
        pc_next_o = pc_i;
        unique case (sel_i)
            PC_HOLD: pc_next_o = pc_i;
            PC_INC:  pc_next_o = pc_i + u64'(INSTR_BYTES);
            PC_JUMP: pc_next_o = jump_pc_i;
            PC_PEND: pc_next_o = pend_pc_i;
            default: pc_next_o = pc_i;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// IF-stage PC generator and single-outstanding ibus initiator feeding dataF to IF/ID.
// Optional FETCH_MISALIGN_CHECK_EN suppresses bus requests for misaligned PCs and flags them.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter u64 PC_RESET    = PC_RESET_DEFAULT,
    parameter int INSTR_BYTES = INSTR_BYTES_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        stallM,
    input  logic        jump,
    input  logic [63:0] jump_pc,
    output ibus_req_t   ireq,
    input  ibus_resp_t  iresp,
    output fetch_data_t dataF,
    output logic        fetch_busy
);

    fetch_state_t state_q, state_d, state_nx;
    u64           pc_q, pc_d;
    u64           pend_q, pend_d;
    logic         pend_valid_q, pend_valid_d;
    u32           instr_q, instr_d, instr_nx;
    pc_sel_t      pc_sel;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic         misalign_q, misalign_d;
`endif

    fetch_unit_pc_sel #(
        .INSTR_BYTES(INSTR_BYTES)
    ) u_pc_sel (
        .sel_i    (pc_sel),
        .pc_i     (pc_q),
        .jump_pc_i(jump_pc),
        .pend_pc_i(pend_q),
        .pc_next_o(pc_d)
    );

    // A request already on the bus cannot be withdrawn, so a redirect arriving
    // before its data is parked in pend_q and the returning data is discarded.
    always_comb begin
        state_nx     = state_q;
        pc_sel       = PC_HOLD;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        instr_nx     = instr_q;

        unique case (state_q)
            IDLE: begin
                if (jump) begin
                    pc_sel = PC_JUMP;
                end
                state_nx = REQ;
            end
            REQ: begin
                if (jump) begin
                    pend_d       = jump_pc;
                    pend_valid_d = 1'b1;
                end
                if (iresp.addr_ok) begin
                    if (jump || pend_valid_q) begin
                        if (iresp.data_ok) begin
                            pc_sel       = jump ? PC_JUMP : PC_PEND;
                            pend_valid_d = 1'b0;
                            state_nx     = REQ;
                        end else begin
                            state_nx = DROP;
                        end
                    end else if (iresp.data_ok) begin
                        instr_nx = iresp.data;
                        state_nx = HOLD;
                    end else begin
                        state_nx = WAIT;
                    end
                end
            end
            WAIT: begin
                if (jump) begin
                    if (iresp.data_ok) begin
                        pc_sel   = PC_JUMP;
                        state_nx = REQ;
                    end else begin
                        pend_d       = jump_pc;
                        pend_valid_d = 1'b1;
                        state_nx     = DROP;
                    end
                end else if (iresp.data_ok) begin
                    instr_nx = iresp.data;
                    state_nx = HOLD;
                end
            end
            HOLD: begin
                if (jump) begin
                    pc_sel   = PC_JUMP;
                    state_nx = REQ;
                end else if (!(stall || stallM)) begin
                    pc_sel   = PC_INC;
                    state_nx = REQ;
                end
            end
            DROP: begin
                if (jump) begin
                    pend_d = jump_pc;
                end
                if (iresp.data_ok) begin
                    pc_sel       = jump ? PC_JUMP : PC_PEND;
                    pend_valid_d = 1'b0;
                    state_nx     = REQ;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_comb begin
        state_d = state_nx;
        instr_d = instr_nx;
`ifdef FETCH_MISALIGN_CHECK_EN
        misalign_d = (state_q == HOLD && state_nx == HOLD) ? misalign_q : 1'b0;
        if (state_nx == REQ && pc_d[1:0] != 2'b00) begin
            state_d    = HOLD;
            instr_d    = '0;
            misalign_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            pc_q         <= PC_RESET;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            instr_q      <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
            misalign_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            instr_q      <= instr_d;
`ifdef FETCH_MISALIGN_CHECK_EN
            misalign_q   <= misalign_d;
`endif
        end
    end

    // Decode only ever sees a payload in HOLD; everything else is driven to zero.
    always_comb begin
        ireq.valid = (state_q == REQ);
        ireq.addr  = pc_q;
        dataF      = '0;
        if (state_q == HOLD) begin
            dataF.valid     = 1'b1;
            dataF.pc        = pc_q;
            dataF.raw_instr = instr_q;
`ifdef FETCH_MISALIGN_CHECK_EN
            dataF.misalign  = misalign_q;
`endif
        end
        fetch_busy = (state_q == REQ) || (state_q == WAIT) || (state_q == DROP);
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a randomized ibus responder and a transaction-level
// fetch model push per-cycle expectations that a separate monitor pops and compares.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        stallM = 1'b0;
    logic        jump = 1'b0;
    logic [63:0] jump_pc = '0;
    ibus_req_t   ireq;
    ibus_resp_t  iresp = '0;
    fetch_data_t dataF;
    logic        fetch_busy;

    fetch_unit dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .stallM    (stallM),
        .jump      (jump),
        .jump_pc   (jump_pc),
        .ireq      (ireq),
        .iresp     (iresp),
        .dataF     (dataF),
        .fetch_busy(fetch_busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        reqValid;
        u64          reqAddr;
        logic        busy;
        fetch_data_t df;
    } expect_t;

    expect_t expQ[$];
    expect_t monExp;
    int compared = 0;
    int mismatched = 0;

    // Reference model: one fetch transaction at a time, killed by any redirect seen while it is open.
    bit mFirst, mInflight, mAcc, mKilled, mPresent;
    u64 mAddr, mRedir, mPpc;
    u32 mPdata;

    bit rspArmed, rspPending, staleNext, cfgDataForce;
    int rspAddrWait, rspDataWait;
    int cfgAddrDelay = -1, cfgDataDelay = -1;
    u32 cfgDataVal, rspData;

    function automatic void modelReset();
        mFirst = 1'b1; mInflight = 1'b0; mAcc = 1'b0; mKilled = 1'b0; mPresent = 1'b0;
        mAddr = PC_RESET_DEFAULT; mRedir = '0; mPpc = '0; mPdata = '0;
    endfunction

    function automatic void startFetch(input u64 a);
        mInflight = 1'b1; mAcc = 1'b0; mKilled = 1'b0; mAddr = a;
    endfunction

    function automatic void modelStep(input bit st, input bit jmp, input u64 jpc, input ibus_resp_t r);
        if (mFirst) begin
            mFirst = 1'b0;
            startFetch(jmp ? jpc : PC_RESET_DEFAULT);
        end else if (mPresent) begin
            if (jmp) begin
                mPresent = 1'b0; startFetch(jpc);
            end else if (!st) begin
                mPresent = 1'b0; startFetch(mPpc + 64'd4);
            end
        end else if (mInflight) begin
            if (jmp) begin
                mKilled = 1'b1; mRedir = jpc;
            end
            if ((mAcc || r.addr_ok) && r.data_ok) begin
                mInflight = 1'b0;
                if (mKilled) startFetch(mRedir);
                else begin
                    mPresent = 1'b1; mPpc = mAddr; mPdata = r.data;
                end
            end else if (r.addr_ok) begin
                mAcc = 1'b1;
            end
        end
    endfunction

    function automatic expect_t modelExpect();
        expect_t e;
        e = '0;
        e.reqValid = mInflight && !mAcc;
        e.reqAddr  = mAddr;
        e.busy     = mInflight;
        if (mPresent) begin
            e.df.valid     = 1'b1;
            e.df.pc        = mPpc;
            e.df.raw_instr = mPdata;
        end
        return e;
    endfunction

    function automatic ibus_resp_t computeResp();
        ibus_resp_t r;
        int dd;
        r = '0;
        if (staleNext) begin
            staleNext = 1'b0;
            r.data_ok = 1'b1;
            r.data    = 32'hDEAD_BEEF;
        end else if (rspPending) begin
            if (rspDataWait == 0) begin
                r.data_ok = 1'b1; r.data = rspData; rspPending = 1'b0;
            end else begin
                rspDataWait--;
            end
        end else if (ireq.valid) begin
            if (!rspArmed) begin
                rspArmed    = 1'b1;
                rspAddrWait = (cfgAddrDelay >= 0) ? cfgAddrDelay : int'($urandom_range(0, 3));
            end
            if (rspAddrWait == 0) begin
                r.addr_ok = 1'b1;
                rspArmed  = 1'b0;
                dd        = (cfgDataDelay >= 0) ? cfgDataDelay : int'($urandom_range(0, 3));
                rspData   = cfgDataForce ? cfgDataVal : u32'($urandom);
                if (dd == 0) begin
                    r.data_ok = 1'b1; r.data = rspData;
                end else begin
                    rspPending = 1'b1; rspDataWait = dd - 1;
                end
            end else begin
                rspAddrWait--;
            end
        end
        return r;
    endfunction

    task automatic applyStimulus(input logic rstn, input logic st, input logic stm,
                                 input logic jmp, input u64 jpc);
        @(negedge clk);
        #1;
        reset = rstn;
        if (!rstn) begin
            iresp = '0; rspArmed = 1'b0; rspPending = 1'b0;
            modelReset();
        end else begin
            iresp = computeResp();
            modelStep(st || stm, jmp, jpc, iresp);
        end
        stall = st; stallM = stm; jump = jmp; jump_pc = jpc;
        expQ.push_back(modelExpect());
    endtask

    function automatic bit reached(input int what);
        return (what == 0) ? mPresent : (mInflight && mAcc && !mKilled);
    endfunction

    task automatic runUntil(input int what, input int maxCycles);
        for (int i = 0; i < maxCycles && !reached(what); i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0);
        if (!reached(what)) begin
            compared++; mismatched++;
            $display("[TB] FAIL wait%0d: not reached after %0d cycles, required reached", what, maxCycles);
        end
    endtask

    task automatic compareVal(input string name, input logic [127:0] act, input logic [127:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, required %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput(input expect_t e);
        compareVal("ireq.valid", 128'(ireq.valid), 128'(e.reqValid));
        if (e.reqValid) compareVal("ireq.addr", 128'(ireq.addr), 128'(e.reqAddr));
        compareVal("fetch_busy", 128'(fetch_busy), 128'(e.busy));
        compareVal("dataF", 128'(dataF), 128'(e.df));
    endtask

    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            monExp = expQ.pop_front();
            checkOutput(monExp);
        end
    end

    initial begin
        u64   jpc;
        logic rstn, st, stm, jmp;
        modelReset();
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0);

        // Zero-latency bus: request at PC_RESET, dataF next cycle, then PC_RESET+4.
        cfgAddrDelay = 0; cfgDataDelay = 0;
        repeat (7) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0);

        cfgAddrDelay = 3; cfgDataDelay = 2;
        repeat (14) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0);

        runUntil(0, 30);
        repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, '0);
        repeat (2) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, '0);
        repeat (4) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0);

        // Redirect in WAIT; the in-flight 0xDEADBEEF must be dropped.
        runUntil(0, 30);
        cfgAddrDelay = 0; cfgDataDelay = 3; cfgDataForce = 1'b1; cfgDataVal = 32'hDEAD_BEEF;
        runUntil(1, 30);
        cfgDataForce = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 64'h8000_0100);
        repeat (8) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0);

        runUntil(0, 30);
        cfgDataDelay = 1;
        runUntil(1, 30);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 64'h8000_0200);
        repeat (4) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0);

        runUntil(0, 30);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 64'h8000_0300);
        repeat (5) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0);

        runUntil(0, 30);
        cfgDataDelay = 0;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8);
        repeat (8) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0);

        // Reset while WAIT, then stale data_ok beats that must be ignored.
        runUntil(0, 30);
        cfgDataDelay = 3;
        runUntil(1, 30);
        repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0);
        staleNext = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0);
        staleNext = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0);
        repeat (8) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0);

        cfgAddrDelay = -1; cfgDataDelay = -1;
        for (int i = 0; i < 3000; i++) begin
            rstn = ($urandom_range(0, 299) != 0);
            st   = ($urandom_range(0, 3) == 0);
            stm  = ($urandom_range(0, 9) == 0);
            jmp  = ($urandom_range(0, 13) == 0);
            jpc  = {$urandom, $urandom} & ~64'h3;
            if ($urandom_range(0, 7) == 0) jpc = 64'hFFFF_FFFF_FFFF_FFF0 | u64'($urandom_range(0, 3) << 2);
            applyStimulus(rstn, st, stm, jmp, jpc);
        end

        repeat (2) @(negedge clk);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- PC generator and instruction-bus initiator for the IF stage.
- Issues one instruction request at a time to the ibus and captures the returned word.
- Presents the captured word and its PC as fetch_data_t (dataF) to the IF/ID pipeline register.
- Handles redirects (jump) and back-pressure (stall, stallM) so decode never sees a stale or duplicated instruction.

Parameters:
- PC_RESET, 64'h8000_0000, PC loaded on reset.
- INSTR_BYTES, 4, PC increment per sequential fetch.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- stall  in  1  decode/hazard stall; hold the current dataF
- stallM  in  1  memory-stage stall; same effect as stall
- jump  in  1  redirect request, one-cycle pulse
- jump_pc  in  64  redirect target, valid when jump=1
- ireq  out  ibus_req_t  {valid, addr}
- iresp  in  ibus_resp_t  {addr_ok, data_ok, data[31:0]}
- dataF  out  fetch_data_t  {valid, pc[63:0], raw_instr[31:0]}
- fetch_busy  out  1  high while a request is outstanding and no instruction is ready

Behaviour:
- Reset (reset=0, async):
  - pc=PC_RESET, state=IDLE.
  - ireq.valid=0, dataF='0, fetch_busy=0.
  - A reset mid-transaction abandons the transaction; any response that arrives after reset is ignored.
- FSM states: IDLE, REQ, WAIT, HOLD, DROP.
- IDLE:
  - Next cycle goes to REQ with ireq.addr=pc.
- REQ:
  - ireq.valid=1; addr stays stable until addr_ok.
  - On addr_ok: if data_ok is also high in the same cycle, treat as a WAIT completion. Otherwise go to WAIT.
- WAIT:
  - ireq.valid=0.
  - On data_ok: capture raw_instr=iresp.data and pc, set dataF.valid=1, go to HOLD.
- HOLD:
  - dataF is stable.
  - When !(stall||stallM): instruction is consumed; pc<=pc+INSTR_BYTES; go to REQ in the next cycle (one-bubble fetch).
  - When stalled: remain in HOLD.
- Redirect (jump=1) has priority over stall:
  - From IDLE or HOLD: pc<=jump_pc, dataF.valid<=0, go to REQ.
  - From REQ before addr_ok: the request cannot be withdrawn. Latch jump_pc as pending redirect, go to DROP after addr_ok.
  - From WAIT: latch jump_pc, go to DROP.
- DROP:
  - Wait for data_ok and discard the data; dataF.valid stays 0.
  - Then pc<=pending target, go to REQ.
  - A further jump while in DROP overwrites the pending target (last wins).
- jump and data_ok in the same cycle in WAIT: the data is discarded and the redirect is taken directly (go to REQ, skip DROP).
- dataF.valid=0 in every state except HOLD. When dataF.valid=0, raw_instr is driven 0.
- fetch_busy = (state ∈ {REQ, WAIT, DROP}).
- PC arithmetic is 64-bit modular; wrap at 2^64 is permitted.

Optional Feature:
- Macro: FETCH_MISALIGN_CHECK_EN.
- With the macro defined:
  - If pc[1:0]!=0 when entering REQ, no ibus request is issued.
  - The unit goes straight to HOLD with raw_instr=0, dataF.valid=1, and an extra field dataF.misalign=1.
- Without the macro:
  - No check; pc[1:0] is driven onto the bus unchanged.
  - The misalign field is absent from fetch_data_t.

Decomposition:
- Package pipes:
  - fetch_data_t, including the conditional misalign field.
  - fetch_state_t enum.
- Package common:
  - ibus_req_t, ibus_resp_t, u1, u32, u64, PC_RESET default.
- One natural sub-module: pc_sel. It is a combinational next-PC mux selecting among hold, pc+4, jump_pc and pending target. The FSM and registers stay in fetch_unit.

Test Plan:
- Reset release with addr_ok and data_ok both 1 in the first REQ cycle:
  - ireq.addr=0x8000_0000.
  - dataF={1, 0x8000_0000, resp data} next cycle.
  - Next request addr=0x8000_0004.
- addr_ok delayed 3 cycles, then data_ok 2 cycles after that:
  - ireq.valid held with a stable addr for 3 cycles.
  - fetch_busy=1 throughout.
  - dataF.valid rises only after data_ok.
- stall=1 for 5 cycles while in HOLD: dataF is unchanged, no ireq.valid, pc is not incremented.
- jump (jump_pc=0x8000_0100) in WAIT, data_ok 2 cycles later with 0xDEADBEEF:
  - 0xDEADBEEF never appears on dataF.
  - Next ireq.addr=0x8000_0100.
- jump and data_ok in the same WAIT cycle: the data is discarded and REQ to jump_pc is issued next cycle. Second case: jump together with stall=1 in HOLD takes the redirect.
- Reset asserted during WAIT, then deasserted; a stale data_ok arrives: ignored. The first request goes to PC_RESET.
